// File: rtl/mips_pkg.sv
// Shared widths and loader state encoding for the boot program loader.
package mips_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PRIME  = 2'b01,
        STREAM = 2'b10,
        DONE   = 2'b11
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Boot-ROM read port and instruction-memory write port driven by the loader.
interface program_loader_if
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0] romAddr;
    logic [DATA_WIDTH-1:0] romData;
    logic                  imemWriteEnable;
    logic [ADDR_WIDTH-1:0] imemAddr;
    logic [DATA_WIDTH-1:0] imemWriteData;

    modport master (
        output romAddr,
        input  romData,
        output imemWriteEnable,
        output imemAddr,
        output imemWriteData
    );

    modport slave (
        input  romAddr,
        output romData,
        input  imemWriteEnable,
        input  imemAddr,
        input  imemWriteData
    );

endinterface

// File: rtl/rising_edge_detect.sv
// One-flop history register; pulse is high for the first cycle a level is seen high.
module rising_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // Clearing the history on reset makes a level held through reset count as an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/program_loader.sv
// Copies PROG_WORDS words from the boot ROM into instruction memory on a start edge.
module program_loader
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PROG_WORDS = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  startProgramLoading,
    program_loader_if.master      mem,
    output logic                  loadBusy,
    output logic                  programLoaded,
    output logic [ADDR_WIDTH:0]   wordCount,
    output logic [DATA_WIDTH-1:0] loadChecksum
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(PROG_WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   LAST_COUNT = (ADDR_WIDTH + 1)'(PROG_WORDS - 1);

    logic start_pulse;

    loader_state_t         state,     state_next;
    logic [ADDR_WIDTH-1:0] rom_addr,  rom_addr_next;
    logic                  we,        we_next;
    logic [ADDR_WIDTH-1:0] imem_addr, imem_addr_next;
    logic [DATA_WIDTH-1:0] imem_data, imem_data_next;
    logic                  busy,      busy_next;
    logic                  loaded,    loaded_next;
    logic [ADDR_WIDTH:0]   count,     count_next;
    logic [DATA_WIDTH-1:0] checksum,  checksum_next;

    rising_edge_detect u_start_edge (
        .clock (clock),
        .reset (reset),
        .level (startProgramLoading),
        .pulse (start_pulse)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rom_addr  <= '0;
            we        <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
            busy      <= 1'b0;
            loaded    <= 1'b0;
            count     <= '0;
            checksum  <= '0;
        end else begin
            state     <= state_next;
            rom_addr  <= rom_addr_next;
            we        <= we_next;
            imem_addr <= imem_addr_next;
            imem_data <= imem_data_next;
            busy      <= busy_next;
            loaded    <= loaded_next;
            count     <= count_next;
            checksum  <= checksum_next;
        end
    end

    always_comb begin
        state_next     = state;
        rom_addr_next  = rom_addr;
        we_next        = 1'b0;
        imem_addr_next = imem_addr;
        imem_data_next = imem_data;
        busy_next      = busy;
        loaded_next    = loaded;
        count_next     = count;
        checksum_next  = checksum;

        case (state)
            IDLE, DONE: begin
                if (state == DONE) begin
                    busy_next   = 1'b0;
                    loaded_next = 1'b1;
                end
                if (start_pulse) begin
                    state_next    = PRIME;
                    rom_addr_next = '0;
                    busy_next     = 1'b1;
                    loaded_next   = 1'b0;
                    count_next    = '0;
                    checksum_next = '0;
                end
            end

            // ROM word 0 is in flight; the address may move on to word 1.
            PRIME: begin
                if (rom_addr < LAST_ADDR) begin
                    rom_addr_next = rom_addr + ADDR_WIDTH'(1);
                end
                state_next = STREAM;
            end

            STREAM: begin
                we_next        = 1'b1;
                imem_addr_next = count[ADDR_WIDTH-1:0];
                imem_data_next = mem.romData;
                count_next     = count + (ADDR_WIDTH + 1)'(1);
                checksum_next  = checksum + mem.romData;
                if (rom_addr < LAST_ADDR) begin
                    rom_addr_next = rom_addr + ADDR_WIDTH'(1);
                end
                if (count == LAST_COUNT) begin
                    state_next = DONE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign mem.romAddr         = rom_addr;
    assign mem.imemWriteEnable = we;
    assign mem.imemAddr        = imem_addr;
    assign mem.imemWriteData   = imem_data;
    assign loadBusy            = busy;
    assign programLoaded       = loaded;
    assign wordCount           = count;
    assign loadChecksum        = checksum;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader at PROG_WORDS = 4, 64, 1 and 256.
module tb_program_loader;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start4, start64, start1, start256;

    program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus4 ();
    program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus64 ();
    program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus256 ();

    logic          busy4, busy64, busy1, busy256;
    logic          loaded4, loaded64, loaded1, loaded256;
    logic [AW:0]   count4, count64, count1, count256;
    logic [DW-1:0] sum4, sum64, sum1, sum256;

    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROG_WORDS(4)) u_dut4 (
        .clock(clk), .reset(rst), .startProgramLoading(start4), .mem(bus4),
        .loadBusy(busy4), .programLoaded(loaded4), .wordCount(count4), .loadChecksum(sum4)
    );
    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROG_WORDS(64)) u_dut64 (
        .clock(clk), .reset(rst), .startProgramLoading(start64), .mem(bus64),
        .loadBusy(busy64), .programLoaded(loaded64), .wordCount(count64), .loadChecksum(sum64)
    );
    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROG_WORDS(1)) u_dut1 (
        .clock(clk), .reset(rst), .startProgramLoading(start1), .mem(bus1),
        .loadBusy(busy1), .programLoaded(loaded1), .wordCount(count1), .loadChecksum(sum1)
    );
    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROG_WORDS(256)) u_dut256 (
        .clock(clk), .reset(rst), .startProgramLoading(start256), .mem(bus256),
        .loadBusy(busy256), .programLoaded(loaded256), .wordCount(count256), .loadChecksum(sum256)
    );

    logic [DW-1:0] rom4 [4];
    initial rom4 = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 32'h9E3779B9 * ({24'h0, a} + 32'd1);
    endfunction

    function automatic logic [DW-1:0] image_sum(input int n);
        logic [DW-1:0] s = '0;
        for (int i = 0; i < n; i++) s = s + rom_word(AW'(i));
        return s;
    endfunction

    // Synchronous boot ROMs: data for the presented address appears one cycle later.
    always @(posedge clk) begin
        bus4.romData   <= rom4[bus4.romAddr[1:0]];
        bus64.romData  <= rom_word(bus64.romAddr);
        bus1.romData   <= rom_word(bus1.romAddr);
        bus256.romData <= rom_word(bus256.romAddr);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] sum4_exp;

    // Start is raised at cycle 0; cycle c is sampled at the negedge after posedge c.
    task automatic load4(input string tag);
        start4 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check($sformatf("%s_busy_c1", tag), 64'(busy4), 64'd1);
                check($sformatf("%s_loaded_c1", tag), 64'(loaded4), 64'd0);
                check($sformatf("%s_count_c1", tag), 64'(count4), 64'd0);
                check($sformatf("%s_sum_c1", tag), 64'(sum4), 64'd0);
            end
            if (c >= 3 && c <= 6) begin
                check($sformatf("%s_we_c%0d", tag, c), 64'(bus4.imemWriteEnable), 64'd1);
                check($sformatf("%s_addr_c%0d", tag, c), 64'(bus4.imemAddr), 64'(c - 3));
                check($sformatf("%s_data_c%0d", tag, c), 64'(bus4.imemWriteData), 64'(rom4[c - 3]));
            end else begin
                check($sformatf("%s_we_c%0d", tag, c), 64'(bus4.imemWriteEnable), 64'd0);
            end
            if (c == 6) check($sformatf("%s_loaded_c6", tag), 64'(loaded4), 64'd0);
            if (c == 7) begin
                check($sformatf("%s_loaded_c7", tag), 64'(loaded4), 64'd1);
                check($sformatf("%s_busy_c7", tag), 64'(busy4), 64'd0);
                check($sformatf("%s_count_c7", tag), 64'(count4), 64'd4);
                check($sformatf("%s_sum_c7", tag), 64'(sum4), 64'(sum4_exp));
            end
        end
    endtask

    initial begin
        int n, bad, extra, drops, last_addr, rise_cyc, strobe_cyc, nonzero;
        bit done, found;

        rst = 1'b1;
        start4 = 1'b0; start64 = 1'b0; start1 = 1'b0; start256 = 1'b0;
        // Plain modulo-2^32 sum of the four image words: 0xED245028.
        sum4_exp = rom4[0] + rom4[1] + rom4[2] + rom4[3];

        repeat (3) @(negedge clk);
        check("rst_we",       64'(bus4.imemWriteEnable), 64'd0);
        check("rst_rom_addr", 64'(bus4.romAddr), 64'd0);
        check("rst_imem_addr", 64'(bus4.imemAddr), 64'd0);
        check("rst_imem_data", 64'(bus4.imemWriteData), 64'd0);
        check("rst_busy",     64'(busy4), 64'd0);
        check("rst_loaded",   64'(loaded4), 64'd0);
        check("rst_count",    64'(count4), 64'd0);
        check("rst_sum",      64'(sum4), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        load4("nominal");

        extra = 0; drops = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus4.imemWriteEnable) extra++;
            if (!loaded4) drops++;
        end
        check("held_extra_strobes", 64'(extra), 64'd0);
        check("held_loaded_drops",  64'(drops), 64'd0);

        start4 = 1'b0;
        @(negedge clk);
        load4("reload");

        // Start retoggled mid-stream must not restart or extend the load.
        start64 = 1'b1;
        n = 0; bad = 0; done = 1'b0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (c == 10) start64 = 1'b0;
            if (c == 12) start64 = 1'b1;
            if (bus64.imemWriteEnable) begin
                if (bus64.imemAddr != AW'(n) || bus64.imemWriteData != rom_word(AW'(n))) bad++;
                n++;
            end
            if (loaded64) done = 1'b1;
        end
        check("toggle_done",    64'(done), 64'd1);
        check("toggle_strobes", 64'(n), 64'd64);
        check("toggle_bad",     64'(bad), 64'd0);
        check("toggle_count",   64'(count64), 64'd64);
        check("toggle_sum",     64'(sum64), 64'(image_sum(64)));
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus64.imemWriteEnable) extra++;
        end
        check("toggle_extra", 64'(extra), 64'd0);

        start64 = 1'b0;
        @(negedge clk);
        start64 = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (bus64.imemWriteEnable && bus64.imemAddr == AW'(10)) found = 1'b1;
        end
        check("midreset_reached_addr10", 64'(found), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midreset_we",        64'(bus64.imemWriteEnable), 64'd0);
        check("midreset_rom_addr",  64'(bus64.romAddr), 64'd0);
        check("midreset_imem_addr", 64'(bus64.imemAddr), 64'd0);
        check("midreset_imem_data", 64'(bus64.imemWriteData), 64'd0);
        check("midreset_busy",      64'(busy64), 64'd0);
        check("midreset_count",     64'(count64), 64'd0);
        check("midreset_sum",       64'(sum64), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Start stays high through reset release, which counts as a fresh edge.
        n = 0; bad = 0; done = 1'b0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (bus64.imemWriteEnable) begin
                if (bus64.imemAddr != AW'(n) || bus64.imemWriteData != rom_word(AW'(n))) bad++;
                n++;
            end
            if (loaded64) done = 1'b1;
        end
        check("reload64_done",    64'(done), 64'd1);
        check("reload64_strobes", 64'(n), 64'd64);
        check("reload64_bad",     64'(bad), 64'd0);
        check("reload64_sum",     64'(sum64), 64'(image_sum(64)));

        start1 = 1'b1;
        n = 0; bad = 0; nonzero = 0; strobe_cyc = -1; rise_cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus1.romAddr != '0) nonzero++;
            if (bus1.imemWriteEnable) begin
                if (bus1.imemAddr != '0 || bus1.imemWriteData != rom_word('0)) bad++;
                n++;
                strobe_cyc = c;
            end
            if (loaded1 && rise_cyc < 0) rise_cyc = c;
        end
        check("w1_strobes",    64'(n), 64'd1);
        check("w1_bad",        64'(bad), 64'd0);
        check("w1_rom_addr",   64'(nonzero), 64'd0);
        check("w1_strobe_cyc", 64'(strobe_cyc), 64'd3);
        check("w1_loaded_cyc", 64'(rise_cyc), 64'd4);
        check("w1_count",      64'(count1), 64'd1);
        check("w1_sum",        64'(sum1), 64'(rom_word('0)));

        start256 = 1'b1;
        n = 0; bad = 0; last_addr = -1; rise_cyc = -1;
        for (int c = 1; c <= 400 && rise_cyc < 0; c++) begin
            @(negedge clk);
            if (bus256.imemWriteEnable) begin
                if (bus256.imemAddr != AW'(n) || bus256.imemWriteData != rom_word(AW'(n))) bad++;
                last_addr = int'(bus256.imemAddr);
                n++;
            end
            if (loaded256) rise_cyc = c;
        end
        check("w256_loaded_cyc", 64'(rise_cyc), 64'd259);
        check("w256_strobes",    64'(n), 64'd256);
        check("w256_bad",        64'(bad), 64'd0);
        check("w256_last_addr",  64'(last_addr), 64'd255);
        check("w256_count",      64'(count256), 64'd256);
        check("w256_sum",        64'(sum256), 64'(image_sum(256)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
